mux_nto1_scan: RTL and testbench

Parametrised, registered N:1 multiplexer with a manual-select mode and an auto-scan mode that sweeps all channels in order with a configurable dwell. It replaces fixed-width 8:1 selection in the datapath, e.g. for time-multiplexing sensor or status channels onto a single output bus. The output is registered and carries a channel tag, a valid flag and an end-of-sweep pulse. Disabled or out-of-range selection holds the last output and drops valid; it never drives X.

---
 rtl/mux_pkg.sv | 15 +
 rtl/scan_counter.sv | 55 +++++
 rtl/mux_nto1_scan.sv | 116 +++++++++++
 tb/tb_mux_nto1_scan.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and encodings for the N:1 registered scan multiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } mux_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_counter.sv
// Channel pointer and dwell counter for the auto-scan sweep.
// Latency: eptr/last are combinational from the registers; they advance one step per enabled edge.
// Backpressure: none; step_en is the only advance qualifier.
module scan_counter #(
    parameter  int N     = 8,
    parameter  int DWELL = 0,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             step_en,
    output logic [SEL_W-1:0] eptr,
    output logic             last
);
    import mux_pkg::*;

    localparam int CNT_W = ($clog2(DWELL + 1) > 1) ? $clog2(DWELL + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ecnt;

    // Outside SCAN the registers are masked to zero, so any entry into SCAN restarts the sweep.
    always_comb begin
        eptr  = active ? ptr_q : '0;
        ecnt  = active ? cnt_q : '0;
        last  = (ecnt == CNT_LAST) && (eptr == PTR_LAST);
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (step_en) begin
            if (ecnt == CNT_LAST) begin
                cnt_d = '0;
                ptr_d = (eptr == PTR_LAST) ? '0 : eptr + 1'b1;
            end else begin
                cnt_d = ecnt + 1'b1;
                ptr_d = eptr;
            end
        end
    end

    // Sweep position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N:1 mux with manual select and auto-scan sweep, tagged with channel/valid/wrap.
// Latency: 1 cycle from din/sel/en/mode to y/ch/valid/wrap.
// Backpressure: none; disabled or illegal selection holds y/ch and drops valid.
module mux_nto1_scan #(
    parameter  int N     = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 0,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   din,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             mode,
    output logic [W-1:0]     y,
    output logic [SEL_W-1:0] ch,
    output logic             valid,
    output logic             wrap
);
    import mux_pkg::*;

    localparam logic [SEL_W:0] N_C = (SEL_W + 1)'(N);

    mux_state_t       state_q, state_d;
    logic [W-1:0]     y_q, y_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic             scan_active;
    logic             scan_step;
    logic [SEL_W-1:0] eptr;
    logic             last;
    logic             sel_ok;
    logic [W-1:0]     man_dat;
    logic [W-1:0]     scan_dat;

    assign scan_active = (state_q == SCAN);
    assign scan_step   = en && (mode == MODE_SCAN);

    scan_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_scan_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (scan_active),
        .step_en (scan_step),
        .eptr    (eptr),
        .last    (last)
    );

    // Channel pick for both sources; compare-based so an illegal sel never reaches an undefined slice.
    always_comb begin
        sel_ok   = ({1'b0, sel} < N_C);
        man_dat  = '0;
        scan_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                man_dat = din[k*W +: W];
            end
            if (eptr == SEL_W'(k)) begin
                scan_dat = din[k*W +: W];
            end
        end
    end

    // Next state and next output values; outputs hold unless a legal sample is taken.
    always_comb begin
        state_d = IDLE;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (en) begin
            if (mode == MODE_SCAN) begin
                state_d = SCAN;
                y_d     = scan_dat;
                ch_d    = eptr;
                valid_d = 1'b1;
                wrap_d  = last;
            end else begin
                state_d = MANUAL;
                if (sel_ok) begin
                    y_d     = man_dat;
                    ch_d    = sel;
                    valid_d = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y     = y_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Self-checking bench: three instances (8:1 dwell 0, 8:1 dwell 1, 6:1 dwell 2) sharing controls.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_mux_nto1_scan;

    localparam int NS [3] = '{8, 8, 6};
    localparam int DS [3] = '{0, 1, 2};

    logic        clk;
    logic        rst_n;
    logic [31:0] din_a;
    logic [47:0] din_c;
    logic [2:0]  sel;
    logic        en;
    logic        mode;

    logic [3:0] y0, y1;
    logic [7:0] y2;
    logic [2:0] ch0, ch1, ch2;
    logic       v0, v1, v2;
    logic       w0, w1, w2;

    int total;
    int bad;

    // Reference model state: sample index since SCAN entry, plus registered outputs.
    int         m_s    [3];
    bit         m_scan [3];
    logic [7:0] m_y    [3];
    logic [2:0] m_ch   [3];
    logic       m_v    [3];
    logic       m_w    [3];

    mux_nto1_scan #(.N(8), .W(4), .DWELL(0)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel), .en(en), .mode(mode),
        .y(y0), .ch(ch0), .valid(v0), .wrap(w0));

    mux_nto1_scan #(.N(8), .W(4), .DWELL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel), .en(en), .mode(mode),
        .y(y1), .ch(ch1), .valid(v1), .wrap(w1));

    mux_nto1_scan #(.N(6), .W(8), .DWELL(2)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din_c), .sel(sel), .en(en), .mode(mode),
        .y(y2), .ch(ch2), .valid(v2), .wrap(w2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] chan_of(int i, int k);
        if (i == 2) return din_c[k*8 +: 8];
        return {4'b0, din_a[k*4 +: 4]};
    endfunction

    function automatic logic [7:0] dut_y(int i);
        case (i)
            0: return {4'b0, y0};
            1: return {4'b0, y1};
            default: return y2;
        endcase
    endfunction

    function automatic logic [2:0] dut_ch(int i);
        case (i)
            0: return ch0;
            1: return ch1;
            default: return ch2;
        endcase
    endfunction

    function automatic logic dut_v(int i);
        case (i)
            0: return v0;
            1: return v1;
            default: return v2;
        endcase
    endfunction

    function automatic logic dut_w(int i);
        case (i)
            0: return w0;
            1: return w1;
            default: return w2;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_s[i] = 0; m_scan[i] = 0;
            m_y[i] = '0; m_ch[i] = '0; m_v[i] = 0; m_w[i] = 0;
        end
    endtask

    // Apply the block's rules to one clock edge using the currently driven inputs.
    task automatic model_edge();
        int n, d, per, c;
        for (int i = 0; i < 3; i++) begin
            n = NS[i]; d = DS[i]; per = n * (d + 1);
            if (!rst_n) begin
                m_s[i] = 0; m_scan[i] = 0;
                m_y[i] = '0; m_ch[i] = '0; m_v[i] = 0; m_w[i] = 0;
            end else if (!en) begin
                m_v[i] = 0; m_w[i] = 0; m_scan[i] = 0;
            end else if (!mode) begin
                m_scan[i] = 0; m_w[i] = 0;
                if (int'(sel) < n) begin
                    m_y[i] = chan_of(i, int'(sel)); m_ch[i] = sel; m_v[i] = 1;
                end else begin
                    m_v[i] = 0;
                end
            end else begin
                if (m_scan[i]) m_s[i] = m_s[i] + 1;
                else           m_s[i] = 0;
                m_scan[i] = 1;
                c = (m_s[i] / (d + 1)) % n;
                m_y[i]  = chan_of(i, c);
                m_ch[i] = 3'(c);
                m_v[i]  = 1;
                m_w[i]  = ((m_s[i] % per) == per - 1);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s u%0d y", tag, i),     32'(dut_y(i)),  32'(m_y[i]));
            check($sformatf("%s u%0d ch", tag, i),    32'(dut_ch(i)), 32'(m_ch[i]));
            check($sformatf("%s u%0d valid", tag, i), 32'(dut_v(i)),  32'(m_v[i]));
            check($sformatf("%s u%0d wrap", tag, i),  32'(dut_w(i)),  32'(m_w[i]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [3:0] y0;
        logic [2:0] ch0;
        logic       v0;
        logic [7:0] y2;
        logic [2:0] ch2;
        logic       v2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0;
        din_a = 32'h7654_3210;
        din_c = 48'h55_44_33_22_11_00;
        model_reset();

        // Manual / out-of-range vectors: channel k of u0 carries k, channel k of u2 carries 0x11*k.
        vecs[0] = '{1'b1, 1'b0, 3'd5, 4'd5, 3'd5, 1'b1, 8'h55, 3'd5, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 3'd2, 4'd2, 3'd2, 1'b1, 8'h22, 3'd2, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 3'd6, 4'd6, 3'd6, 1'b1, 8'h22, 3'd2, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 3'd7, 4'd7, 3'd7, 1'b1, 8'h22, 3'd2, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 3'd4, 4'd4, 3'd4, 1'b1, 8'h44, 3'd4, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 3'd1, 4'd4, 3'd4, 1'b0, 8'h44, 3'd4, 1'b0};

        // Reset state.
        do_reset();
        check("rst y0", 32'(y0), 0);
        check("rst ch0", 32'(ch0), 0);
        check("rst v0", 32'(v0), 0);
        check("rst w0", 32'(w0), 0);
        check("rst y2", 32'(y2), 0);
        check_all("rst");

        // Table-driven manual mode.
        for (int i = 0; i < 6; i++) begin
            en = vecs[i].en; mode = vecs[i].mode; sel = vecs[i].sel;
            tick();
            check($sformatf("vec%0d y0", i),  32'(y0),  32'(vecs[i].y0));
            check($sformatf("vec%0d ch0", i), 32'(ch0), 32'(vecs[i].ch0));
            check($sformatf("vec%0d v0", i),  32'(v0),  32'(vecs[i].v0));
            check($sformatf("vec%0d y2", i),  32'(y2),  32'(vecs[i].y2));
            check($sformatf("vec%0d ch2", i), 32'(ch2), 32'(vecs[i].ch2));
            check($sformatf("vec%0d v2", i),  32'(v2),  32'(vecs[i].v2));
            check($sformatf("vec%0d w0", i),  32'(w0),  0);
            check_all($sformatf("vec%0d", i));
        end

        // Scan sweep from a fresh entry: dwell 0 and dwell 1 side by side.
        do_reset();
        en = 1'b1; mode = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            check($sformatf("scan%0d ch0", i), 32'(ch0), 32'(i % 8));
            check($sformatf("scan%0d y0", i),  32'(y0),  32'(i % 8));
            check($sformatf("scan%0d w0", i),  32'(w0),  32'((i % 8) == 7));
            check($sformatf("scan%0d ch1", i), 32'(ch1), 32'((i / 2) % 8));
            check($sformatf("scan%0d w1", i),  32'(w1),  32'(i == 15));
            check_all($sformatf("scan%0d", i));
        end

        // Mid-sweep mode switch: manual takes over, scan restarts at channel 0.
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1;
        tick();
        for (int k = 0; k < 20 && ch0 != 3'd3; k++) tick();
        check("reach ch3", 32'(ch0), 3);
        mode = 1'b0; sel = 3'd6;
        tick();
        check("intr man ch0", 32'(ch0), 6);
        check("intr man v0", 32'(v0), 1);
        check("intr man w0", 32'(w0), 0);
        check_all("intr man");
        mode = 1'b1;
        tick();
        check("restart ch0", 32'(ch0), 0);
        check("restart ch1", 32'(ch1), 0);
        check("restart ch2", 32'(ch2), 0);
        check_all("restart");

        // Drop en on the last dwell of channel 7 (dwell-1 instance): no wrap, y holds.
        for (int k = 0; k < 14; k++) begin
            tick();
            check_all("pre drop");
        end
        check("pre drop ch1", 32'(ch1), 7);
        check("pre drop w1", 32'(w1), 0);
        en = 1'b0;
        tick();
        check("drop v1", 32'(v1), 0);
        check("drop w1", 32'(w1), 0);
        check("drop y1", 32'(y1), 7);
        check_all("drop");

        // Async reset mid-sweep, then restart with scan still requested.
        en = 1'b1; mode = 1'b1;
        tick();
        for (int k = 0; k < 20 && ch0 != 3'd4; k++) tick();
        check("reach ch4", 32'(ch0), 4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst y0", 32'(y0), 0);
        check("arst ch0", 32'(ch0), 0);
        check("arst v0", 32'(v0), 0);
        check("arst ch1", 32'(ch1), 0);
        check("arst ch2", 32'(ch2), 0);
        check_all("arst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst ch0", 32'(ch0), 0);
        check("post rst v0", 32'(v0), 1);
        check("post rst ch1", 32'(ch1), 0);
        check("post rst ch2", 32'(ch2), 0);
        check_all("post rst");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            mode = ($urandom_range(0, 3) != 0);
            sel  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                din_a = $urandom;
                din_c = {16'($urandom), $urandom};
            end
            tick();
            check_all($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
